// File: rtl/alu_stream_pkg.sv
// Shared types and defaults for the ALU result-stream blocks (join, fork, slots).
package alu_stream_pkg;

  localparam int DATA_IN_WIDTH_DEFAULT = 8;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage : alu_stream_pkg

// File: rtl/stream_slot.sv
// One-entry registered output slot: loads on 'load', empties on consumer handshake.
module stream_slot
  import alu_stream_pkg::*;
#(
  parameter int WIDTH = DATA_IN_WIDTH_DEFAULT + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  input  logic             ready,
  output logic             can_load
);

  slot_state_t      state_q;
  slot_state_t      state_d;
  logic [WIDTH-1:0] data_p1;

  // Stage boundary: slot register; data only changes on a load, so a stalled word holds
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SLOT_EMPTY;
      data_p1 <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        data_p1 <= d;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SLOT_EMPTY: begin
        if (load) state_d = SLOT_FULL;
      end
      SLOT_FULL: begin
        // A load wins over a drain in the same cycle: old word leaves, new one lands
        if (load)       state_d = SLOT_FULL;
        else if (ready) state_d = SLOT_EMPTY;
      end
      default: state_d = SLOT_EMPTY;
    endcase
  end

  assign q        = data_p1;
  assign valid    = (state_q == SLOT_FULL);
  assign can_load = !valid || ready;

endmodule : stream_slot

// File: rtl/stream_fork.sv
// Valid/ready broadcaster: one input stream copied to two independently drained slots.
module stream_fork
  import alu_stream_pkg::*;
#(
  parameter int DATA_IN_WIDTH = DATA_IN_WIDTH_DEFAULT
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [DATA_IN_WIDTH:0] in,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DATA_IN_WIDTH:0] out_A,
  output logic                   out_A_valid,
  input  logic                   out_A_ready,
  output logic [DATA_IN_WIDTH:0] out_B,
  output logic                   out_B_valid,
  input  logic                   out_B_ready
);

  logic can_a;
  logic can_b;
  logic load;

  // Lockstep at the input: a word is taken only when both branches can hold it
  assign in_ready = can_a && can_b && !rst_i;
  assign load     = in_valid && in_ready;

  stream_slot #(
    .WIDTH(DATA_IN_WIDTH + 1)
  ) u_slot_a (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load    (load),
    .d       (in),
    .q       (out_A),
    .valid   (out_A_valid),
    .ready   (out_A_ready),
    .can_load(can_a)
  );

  stream_slot #(
    .WIDTH(DATA_IN_WIDTH + 1)
  ) u_slot_b (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load    (load),
    .d       (in),
    .q       (out_B),
    .valid   (out_B_valid),
    .ready   (out_B_ready),
    .can_load(can_b)
  );

endmodule : stream_fork

// File: tb/tb_stream_fork.sv
// Self-checking bench for stream_fork: directed vector table, corner sequences, random scoreboard.
module tb_stream_fork;

  localparam int W      = 9;
  localparam int NWORDS = 1000;
  localparam int BUDGET = 50000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] din = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] out_a;
  logic         out_a_valid;
  logic         out_a_ready = 1'b0;
  logic [W-1:0] out_b;
  logic         out_b_valid;
  logic         out_b_ready = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  stream_fork #(.DATA_IN_WIDTH(W-1)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in         (din),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_A      (out_a),
    .out_A_valid(out_a_valid),
    .out_A_ready(out_a_ready),
    .out_B      (out_b),
    .out_B_valid(out_b_valid),
    .out_B_ready(out_b_ready)
  );

  // Protocol properties
  assert property (@(posedge clk) disable iff (rst)
    (out_a_valid && !out_a_ready) |=> (out_a_valid && $stable(out_a)))
  else begin n_fail++; $display("FAIL sva_a_hold at %0t", $time); end

  assert property (@(posedge clk) disable iff (rst)
    (out_b_valid && !out_b_ready) |=> (out_b_valid && $stable(out_b)))
  else begin n_fail++; $display("FAIL sva_b_hold at %0t", $time); end

  assert property (@(posedge clk) rst |-> !in_ready)
  else begin n_fail++; $display("FAIL sva_ready_in_reset at %0t", $time); end

  typedef struct {
    logic [W-1:0] d;
    logic         v;
    logic         ra;
    logic         rb;
    logic         ir;
    logic [W-1:0] ea;
    logic         eav;
    logic [W-1:0] eb;
    logic         ebv;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic add(input logic [W-1:0] d, input logic v, ra, rb, ir,
                     input logic [W-1:0] ea, input logic eav,
                     input logic [W-1:0] eb, input logic ebv);
    vec_t t;
    t.d = d; t.v = v; t.ra = ra; t.rb = rb; t.ir = ir;
    t.ea = ea; t.eav = eav; t.eb = eb; t.ebv = ebv;
    vecs.push_back(t);
  endtask

  // Drive one cycle, check in_ready before the edge and outputs after it
  task automatic step(input vec_t t, input string tag);
    din = t.d; in_valid = t.v; out_a_ready = t.ra; out_b_ready = t.rb;
    #1;
    chk({tag, "_in_ready"}, in_ready, t.ir);
    @(posedge clk); #1;
    chk({tag, "_a_valid"}, out_a_valid, t.eav);
    chk({tag, "_a_data"},  out_a,       t.ea);
    chk({tag, "_b_valid"}, out_b_valid, t.ebv);
    chk({tag, "_b_data"},  out_b,       t.eb);
  endtask

  task automatic reset_cycle(input string tag);
    rst = 1'b1; in_valid = 1'b0;
    #1;
    chk({tag, "_in_ready"}, in_ready, 0);
    @(posedge clk); #1;
    chk({tag, "_a_valid"}, out_a_valid, 0);
    chk({tag, "_a_data"},  out_a,       0);
    chk({tag, "_b_valid"}, out_b_valid, 0);
    chk({tag, "_b_data"},  out_b,       0);
    rst = 1'b0;
  endtask

  initial begin
    vec_t t;
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    int unsigned duty[3];
    int sent, got_a, got_b, cyc, k;
    logic ra, rb, iv, exp_ir;
    logic [W-1:0] d;

    duty[0] = 25; duty[1] = 50; duty[2] = 90;

    // Directed table: single word, B stall, held data under stall, one-sided full
    add(9'h1FE, 1, 1, 1, 1, 9'h1FE, 1, 9'h1FE, 1);
    add(9'h000, 0, 1, 1, 1, 9'h1FE, 0, 9'h1FE, 0);
    add(9'h055, 1, 1, 1, 1, 9'h055, 1, 9'h055, 1);
    for (int i = 0; i < 5; i++) add(9'h0AA, 1, 1, 0, 0, 9'h055, 0, 9'h055, 1);
    add(9'h0AA, 1, 1, 1, 1, 9'h0AA, 1, 9'h0AA, 1);
    add(9'h000, 0, 1, 1, 1, 9'h0AA, 0, 9'h0AA, 0);
    add(9'h077, 1, 1, 1, 1, 9'h077, 1, 9'h077, 1);
    add(9'h0EE, 1, 0, 0, 0, 9'h077, 1, 9'h077, 1);
    add(9'h0EE, 0, 0, 0, 0, 9'h077, 1, 9'h077, 1);
    add(9'h0EE, 0, 1, 1, 1, 9'h077, 0, 9'h077, 0);
    add(9'h033, 1, 1, 1, 1, 9'h033, 1, 9'h033, 1);
    add(9'h000, 0, 0, 1, 0, 9'h033, 1, 9'h033, 0);
    add(9'h044, 1, 1, 0, 1, 9'h044, 1, 9'h044, 1);
    add(9'h000, 0, 1, 1, 1, 9'h044, 0, 9'h044, 0);

    reset_cycle("reset0");
    reset_cycle("reset1");

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back stream with both consumers always ready
    for (int i = 0; i <= 16; i++) begin
      t.d = W'(i); t.v = (i < 16); t.ra = 1; t.rb = 1; t.ir = 1;
      t.ea = (i < 16) ? W'(i) : W'(15); t.eav = (i < 16);
      t.eb = t.ea; t.ebv = t.eav;
      step(t, $sformatf("b2b%0d", i));
    end

    // Reset while A is empty and B still holds a word
    t = '{9'h123, 1, 1, 1, 1, 9'h123, 1, 9'h123, 1};
    step(t, "mid_load");
    t = '{9'h000, 0, 1, 0, 0, 9'h123, 0, 9'h123, 1};
    step(t, "mid_adrain");
    out_b_ready = 1'b0;
    reset_cycle("mid_reset");
    t = '{9'h001, 1, 1, 1, 1, 9'h001, 1, 9'h001, 1};
    step(t, "mid_after");
    t = '{9'h000, 0, 1, 1, 1, 9'h001, 0, 9'h001, 0};
    step(t, "mid_drain");

    // Random readies and upstream valid against a queue model
    sent = 0; got_a = 0; got_b = 0; cyc = 0;
    while ((sent < NWORDS || qa.size() != 0 || qb.size() != 0) && cyc < BUDGET) begin
      k  = (cyc / 150) % 9;
      ra = ($urandom_range(99) < duty[k % 3]);
      rb = ($urandom_range(99) < duty[k / 3]);
      iv = (sent < NWORDS) && ($urandom_range(99) < 70);
      d  = W'($urandom_range(511));
      din = d; in_valid = iv; out_a_ready = ra; out_b_ready = rb;
      #1;
      exp_ir = (qa.size() == 0 || ra) && (qb.size() == 0 || rb);
      chk("rnd_in_ready", in_ready, exp_ir);
      chk("rnd_a_valid", out_a_valid, qa.size() != 0);
      chk("rnd_b_valid", out_b_valid, qb.size() != 0);
      if (qa.size() != 0 && ra) begin
        chk("rnd_a_data", out_a, qa[0]);
        void'(qa.pop_front());
        got_a++;
      end
      if (qb.size() != 0 && rb) begin
        chk("rnd_b_data", out_b, qb[0]);
        void'(qb.pop_front());
        got_b++;
      end
      if (iv && exp_ir) begin
        qa.push_back(d);
        qb.push_back(d);
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("rnd_budget", (cyc < BUDGET), 1);
    chk("rnd_a_count", got_a, NWORDS);
    chk("rnd_b_count", got_b, NWORDS);

    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("final_a_valid", out_a_valid, 0);
    chk("final_b_valid", out_b_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_stream_fork
